// File: rtl/cas_tape_player.sv
// Cassette image player: buffers a downloaded .CAS image in block RAM and
// replays it MSB first as a pulse-encoded tape signal (one pulse = 0, two = 1).
module cas_tape_player #(
  parameter int ADDR_W       = 17,
  parameter int BIT_CYCLES   = 29556,
  parameter int PULSE_CYCLES = 3695
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  output logic              ioctl_wait,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              play,
  input  logic              rewind,
  input  logic              eject,
  output logic [12:0]       status,
  output logic [47:0]       system_tape_filename,
  output logic              tape
);
  localparam int TMR_W = $clog2(BIT_CYCLES);
  localparam logic [TMR_W-1:0] LAST      = TMR_W'(BIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_END = TMR_W'(PULSE_CYCLES);
  localparam logic [TMR_W-1:0] HALF_T    = TMR_W'(BIT_CYCLES / 2);
  localparam logic [TMR_W-1:0] HALF_END  = TMR_W'(BIT_CYCLES / 2 + PULSE_CYCLES);

  logic [7:0]        ram [2**ADDR_W];
  logic [7:0]        rd_data_p1;
  logic [ADDR_W-1:0] rd_addr;

  logic              loaded    = 1'b0;
  logic [ADDR_W:0]   tape_len  = '0;
  logic [47:0]       filename  = '0;
  logic              fn_found  = 1'b0;
  logic              prev_66   = 1'b0;
  logic [2:0]        fn_cnt    = '0;

  logic              playing    = 1'b0;
  logic [ADDR_W:0]   position   = '0;
  logic [TMR_W-1:0]  bit_timer  = '0;
  logic [2:0]        bit_idx    = '0;
  logic [7:0]        shreg      = '0;
  logic              byte_vld   = 1'b0;
  logic              fetch_wait = 1'b0;

  logic play_q = 1'b0, rewind_q = 1'b0, eject_q = 1'b0, dl_q = 1'b0;
  logic dl_rise, dl_fall, eject_fire, rewind_fire, play_fire, pulse_on;
  logic        found_e, prev_e;
  logic [2:0]  cnt_e;
  logic [47:0] fn_e;

  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  assign eject_fire  = eject & ~eject_q & ~playing & ~ioctl_download & ~reset;
  assign rewind_fire = rewind & ~rewind_q & loaded & ~playing & ~eject_fire;
  assign play_fire   = play & ~play_q & loaded & (position < tape_len)
                       & ~eject_fire & ~rewind_fire;

  // Capture state as it will be once a download start has cleared it.
  assign found_e = dl_rise ? 1'b0 : fn_found;
  assign prev_e  = dl_rise ? 1'b0 : prev_66;
  assign cnt_e   = dl_rise ? 3'd0 : fn_cnt;
  assign fn_e    = dl_rise ? 48'd0 : filename;

  // While a byte is being shifted out, prefetch the following one.
  assign rd_addr = byte_vld ? position[ADDR_W-1:0] + ADDR_W'(1) : position[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (ioctl_download && ioctl_wr) ram[ioctl_addr] <= ioctl_dout;
    rd_data_p1 <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (dl_rise) begin
      loaded   <= 1'b0;
      tape_len <= '0;
      filename <= '0;
      fn_found <= 1'b0;
      prev_66  <= 1'b0;
      fn_cnt   <= '0;
    end
    if (ioctl_download && ioctl_wr) begin
      tape_len <= {1'b0, ioctl_addr} + (ADDR_W + 1)'(1);
      prev_66  <= (ioctl_dout == 8'h66);
      if (found_e && cnt_e != 3'd6) begin
        filename <= {fn_e[39:0], ioctl_dout};
        fn_cnt   <= cnt_e + 3'd1;
      end else if (!found_e && prev_e && ioctl_dout == 8'h55 && ioctl_addr < ADDR_W'(512)) begin
        fn_found <= 1'b1;
      end
    end
    if (dl_fall) begin
      loaded <= (tape_len != '0);
      if (fn_found && fn_cnt != 3'd6) filename <= '0;
    end else if (eject_fire) begin
      loaded   <= 1'b0;
      tape_len <= '0;
      filename <= '0;
    end
  end

  always_ff @(posedge clk) begin
    play_q   <= play;
    rewind_q <= rewind;
    eject_q  <= eject;
    dl_q     <= ioctl_download;
    if (reset || ioctl_download || eject_fire || rewind_fire) begin
      playing    <= 1'b0;
      position   <= '0;
      bit_timer  <= '0;
      bit_idx    <= '0;
      byte_vld   <= 1'b0;
      fetch_wait <= 1'b0;
    end else begin
      if (play_fire) playing <= ~playing;
      if (playing) begin
        if (!byte_vld) begin
          // RAM read latency: address settles one cycle, data lands the next.
          if (fetch_wait) begin
            shreg      <= rd_data_p1;
            byte_vld   <= 1'b1;
            fetch_wait <= 1'b0;
            bit_timer  <= '0;
            bit_idx    <= '0;
          end else begin
            fetch_wait <= 1'b1;
          end
        end else if (bit_timer == LAST) begin
          bit_timer <= '0;
          if (bit_idx == 3'd7) begin
            bit_idx  <= '0;
            position <= position + (ADDR_W + 1)'(1);
            shreg    <= rd_data_p1;
            if (position + (ADDR_W + 1)'(1) == tape_len) begin
              playing  <= 1'b0;
              byte_vld <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end else begin
          bit_timer <= bit_timer + TMR_W'(1);
        end
      end
    end
  end

  assign pulse_on = (bit_timer < PULSE_END)
                    || (shreg[7] && bit_timer >= HALF_T && bit_timer < HALF_END);
  assign tape                 = playing & byte_vld & pulse_on;
  assign status               = {11'(position[ADDR_W-1:6]), playing, loaded};
  assign system_tape_filename = filename;
  assign ioctl_wait           = 1'b0;
endmodule

// File: tb/tb_cas_tape_player.sv
// Bench for cas_tape_player: a play-time model predicts status, tape and
// filename every cycle; directed scenarios add hand-computed spot checks.
module tb_cas_tape_player;
  localparam int AW = 17;
  localparam int BC = 40;
  localparam int PC = 5;

  logic          clk = 1'b0;
  logic          reset, ioctl_download, ioctl_wait, ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          play, rewind, eject, tape;
  logic [12:0]   status;
  logic [47:0]   system_tape_filename;

  always #5 clk = ~clk;

  cas_tape_player #(.ADDR_W(AW), .BIT_CYCLES(BC), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .play(play), .rewind(rewind), .eject(eject), .status(status),
    .system_tape_filename(system_tape_filename), .tape(tape)
  );

  int total = 0;
  int bad = 0;

  // Model: image contents, load state, and elapsed play time since position 0.
  logic [7:0]  img [0:1023];
  logic [7:0]  src [0:1023];
  bit          m_loaded = 0, m_playing = 0, m_fresh = 1, m_dl = 0;
  bit          q_play = 0, q_rew = 0, q_ej = 0;
  int          m_len = 0, m_t = 0, m_lat = 0;
  logic [47:0] m_fn = '0;
  logic        tw [0:319];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] find_name();
    for (int i = 0; i + 1 < m_len; i++) begin
      if (img[i] == 8'h66 && img[i+1] == 8'h55 && i + 1 < 512) begin
        if (i + 7 < m_len) return {img[i+2], img[i+3], img[i+4], img[i+5], img[i+6], img[i+7]};
        return '0;
      end
    end
    return '0;
  endfunction

  function automatic logic [12:0] exp_status();
    int pos;
    pos = m_t / (8 * BC);
    return {11'(pos >> 6), m_playing, m_loaded};
  endfunction

  function automatic logic exp_tape();
    int byte_i, bit_i, ph;
    logic b;
    if (!m_playing || m_lat > 0) return 1'b0;
    byte_i = m_t / (8 * BC);
    bit_i  = (m_t / BC) % 8;
    ph     = m_t % BC;
    b      = img[byte_i][7 - bit_i];
    return (ph < PC) || (b && ph >= BC / 2 && ph < BC / 2 + PC);
  endfunction

  task automatic model_step();
    bit pe, re, ee, dr, df, ef, rf, pf, op;
    int pos;
    pe = play && !q_play;
    re = rewind && !q_rew;
    ee = eject && !q_ej;
    dr = ioctl_download && !m_dl;
    df = !ioctl_download && m_dl;
    q_play = play; q_rew = rewind; q_ej = eject; m_dl = ioctl_download;
    pos = m_t / (8 * BC);
    ef = ee && !m_playing && !ioctl_download && !reset;
    rf = re && m_loaded && !m_playing && !ef;
    pf = pe && m_loaded && (pos < m_len) && !ef && !rf;
    if (dr) begin m_loaded = 0; m_len = 0; m_fn = '0; end
    if (ioctl_download && ioctl_wr) begin
      img[ioctl_addr] = ioctl_dout;
      m_len = int'(ioctl_addr) + 1;
    end
    if (df) begin
      m_loaded = (m_len > 0);
      m_fn = find_name();
    end else if (ef) begin
      m_loaded = 0; m_len = 0; m_fn = '0;
    end
    if (reset || ioctl_download || ef || rf) begin
      m_playing = 0; m_t = 0; m_lat = 0; m_fresh = 1;
    end else begin
      op = m_playing;
      if (pf) begin
        m_playing = !op;
        if (!op && m_fresh) begin m_lat = 2; m_fresh = 0; end
      end
      if (op) begin
        if (m_lat > 0) m_lat--;
        else begin
          m_t++;
          if (m_t == m_len * 8 * BC) begin m_playing = 0; m_fresh = 1; end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!m_dl) begin
      check("status", 64'(status), 64'(exp_status()));
      check("tape", 64'(tape), 64'(exp_tape()));
      check("filename", 64'(system_tape_filename), 64'(m_fn));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) play = 1'b1; else if (which == 1) rewind = 1'b1; else eject = 1'b1;
    tick();
    play = 1'b0; rewind = 1'b0; eject = 1'b0;
    tick();
  endtask

  task automatic download(input int n);
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(i); ioctl_dout = src[i];
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    ioctl_download = 1'b0;
    tick(2);
  endtask

  initial begin
    int   highs, maxc;
    bit   done;
    logic [7:0] colour [0:7];
    for (int i = 0; i < 1024; i++) begin img[i] = 8'h00; src[i] = 8'h00; end
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    play = 1'b0; rewind = 1'b0; eject = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
    check("reset_status", 64'(status), 64'd0);
    check("reset_tape", 64'(tape), 64'd0);
    check("ioctl_wait", 64'(ioctl_wait), 64'd0);

    colour = '{8'h66, 8'h55, "C", "O", "L", "O", "U", "R"};
    for (int i = 0; i < 16; i++) src[i] = (i < 8) ? colour[i] : 8'(i * 3);
    download(16);
    check("colour_loaded", 64'(status[0]), 64'd1);
    check("colour_name", 64'(system_tape_filename), 64'h434F4C4F5552);

    src[0] = 8'h66; src[1] = 8'h12; src[2] = 8'h55; src[3] = 8'h66;
    download(4);
    check("nopair_loaded", 64'(status), 64'd1);
    check("nopair_name", 64'(system_tape_filename), 64'd0);
    pulse(2);
    check("eject_status", 64'(status), 64'd0);
    check("eject_name", 64'(system_tape_filename), 64'd0);

    src[0] = 8'h10; src[1] = 8'h66; src[2] = 8'h55; src[3] = "A"; src[4] = "B";
    download(5);
    check("short_name", 64'(system_tape_filename), 64'd0);

    for (int i = 0; i < 520; i++) src[i] = "A";
    src[511] = 8'h66; src[512] = 8'h55;
    download(520);
    check("late_pair_name", 64'(system_tape_filename), 64'd0);

    src[0] = 8'hA0;
    download(1);
    pulse(0);
    for (int k = 0; k < 320; k++) begin tick(); tw[k] = tape; end
    highs = 0;
    for (int k = 0; k < 320; k++) highs += int'(tw[k]);
    check("a0_high_cycles", 64'(highs), 64'd50);
    check("a0_c0_p0", 64'(tw[0]), 64'd1);
    check("a0_c0_p5", 64'(tw[5]), 64'd0);
    check("a0_c0_p20", 64'(tw[20]), 64'd1);
    check("a0_c0_p25", 64'(tw[25]), 64'd0);
    check("a0_c1_p20", 64'(tw[60]), 64'd0);
    check("a0_c2_p24", 64'(tw[104]), 64'd1);
    check("a0_c7_p4", 64'(tw[284]), 64'd1);
    tick(2);
    check("a0_end_status", 64'(status), 64'd1);
    pulse(0);
    check("a0_play_at_end", 64'(status), 64'd1);

    src[0] = 8'h5A; src[1] = 8'hC3; src[2] = 8'hFF; src[3] = 8'h00;
    download(4);
    pulse(0);
    tick(30);
    pulse(1);
    check("rewind_while_playing", 64'(status[1]), 64'd1);
    tick(47);
    pulse(0);
    check("paused", 64'(status[1]), 64'd0);
    tick(100);
    check("paused_tape", 64'(tape), 64'd0);
    pulse(0);
    check("resumed", 64'(status[1]), 64'd1);
    tick(200);
    pulse(0);
    pulse(1);
    check("rewound_status", 64'(status), 64'd1);
    pulse(0);
    tick(150);

    colour = '{8'h66, 8'h55, "T", "A", "P", "E", "0", "1"};
    for (int i = 0; i < 200; i++) src[i] = (i < 8) ? colour[i] : 8'(i * 37 + 11);
    download(200);
    check("tape01_name", 64'(system_tape_filename), 64'h544150453031);
    pulse(0);
    done = 0; maxc = 0;
    for (int i = 0; i < 66000 && !done; i++) begin
      tick();
      if (int'(status[12:2]) > maxc) maxc = int'(status[12:2]);
      if (!status[1]) done = 1;
    end
    check("end_reached", 64'(done), 64'd1);
    check("max_counter", 64'(maxc), 64'd3);
    check("end_status", 64'(status), 64'd13);
    pulse(0);
    check("play_ignored_at_end", 64'(status[1]), 64'd0);
    pulse(1);
    check("rewind_at_end", 64'(status), 64'd1);
    pulse(0);
    tick(500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_play_status", 64'(status), 64'd1);
    check("reset_play_tape", 64'(tape), 64'd0);
    check("reset_play_name", 64'(system_tape_filename), 64'h544150453031);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cas_tape_player.md
Name: cas_tape_player

Overview:
- Cassette (.CAS) player for the EG2000 / Colour Genie core.
- Captures a CAS image downloaded over the ioctl bus into internal block RAM.
- Replays it as a pulse-encoded 1-bit tape signal into the machine's cassette input.
- Exposes load/play status, a tape counter and the 6-character system-tape filename for the OSD and paste logic.

Parameters:
- ADDR_W, 17: byte-address width of tape buffer; depth = 2^ADDR_W bytes.
- BIT_CYCLES, 29556: clk cycles per bit cell (about 1200 baud at 35.47 MHz).
- PULSE_CYCLES, 3695: clk cycles that tape is held high per pulse.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high while this block's file (index 1) is downloading.
- ioctl_wait  out  1  download stall; constant 0.
- ioctl_wr  in  1  byte write strobe, one cycle.
- ioctl_addr  in  ADDR_W  byte address of ioctl_dout.
- ioctl_dout  in  8  download data byte.
- play  in  1  play/pause request, level; acted on rising edge.
- rewind  in  1  rewind request, level; acted on rising edge.
- eject  in  1  eject request, level; acted on rising edge.
- status  out  13  [0] loaded, [1] playing, [12:2] tape counter.
- system_tape_filename  out  48  6 ASCII chars, first char in [47:40]; 0 if none.
- tape  out  1  cassette signal to machine.

Behaviour:
- Power-up (register init): all state 0.
- reset: playing=0, position=0, bit/pulse timers cleared, tape=0; loaded, length, filename and RAM contents retained.
- Edge detect: play, rewind, eject registered once per clk; each acts on its 0->1 transition only.
- Download, while ioctl_download=1:
  - playing forced 0, position=0.
  - Each ioctl_wr writes ioctl_dout to RAM[ioctl_addr]; length = ioctl_addr+1.
  - Download rising edge clears loaded, length, filename.
- Download end (1->0): loaded=1 if length>0.
- Filename capture, on-the-fly during download writes:
  - Trigger: first occurrence of byte 0x66 immediately followed by 0x55 with address < 512.
  - The next 6 bytes are shifted into system_tape_filename, first char ending in [47:40].
  - If the image ends before 6 chars are captured, the filename is cleared to 0.
- Play edge:
  - If loaded and position<length: toggle playing.
  - Otherwise ignored.
- Rewind edge: if loaded and not playing, position=0 and timers cleared; else ignored.
- Eject edge, only when not playing:
  - Clears loaded, length, filename and position.
  - Tape stays 0.
- Playback, when playing:
  - Fetch RAM[position] (1-cycle RAM read latency absorbed before first cell).
  - Serialize MSB first, one bit per BIT_CYCLES.
  - Every cell: tape=1 for cycles [0, PULSE_CYCLES), then 0.
  - Bit 1 only: additional pulse at [BIT_CYCLES/2, BIT_CYCLES/2+PULSE_CYCLES).
  - After 8 cells, position++ and the next byte is fetched with no gap between cells.
- End of tape: when position reaches length, playing=0 and position stays at length; a play edge there is ignored until rewind.
- Pause: playing=0 freezes bit timer, bit index and position; tape=0 while paused; resume continues the same cell.
- Counter: status[12:2] = position[ADDR_W-1:6] (wraps naturally in 11 bits).
- Simultaneous edges in one cycle, priority: eject > rewind > play (each still subject to its own conditions).
- Writes with download inactive are ignored.

Test Plan:
- Download 16 bytes [0x66,0x55,'C','O','L','O','U','R',...] -> status[0]=1, length=16, filename=0x434F4C4F5552.
- Download image with no 0x66,0x55 pair -> filename=0, loaded=1; eject edge -> status=0, filename=0.
- Load byte 0xA0, play, BIT_CYCLES=40, PULSE_CYCLES=5 -> pulses:
  - cell 0: cycles 0-4 and 20-24;
  - cell 1: 0-4 only;
  - cell 2: 0-4 and 20-24;
  - cells 3-7: 0-4 only.
  Then playing=0, position=1.
- Play, then pause mid-cell, wait 100 cycles, play -> waveform resumes exactly where frozen; rewind during play ignored; rewind after pause -> counter 0.
- Play a 200-byte image to end -> status[12:2] reaches 3 (200>>6), playing clears; play edge ignored until rewind.
- Assert reset during playback -> playing=0, position=0, tape=0, status[0] still 1, filename unchanged.
